// File: rtl/sda_action_memfill_gmem_if.sv
// AXI4 bundle for the single gmem port of the memfill action.
// The master modport is the action side; the slave modport is the memory/interconnect side.
interface sda_action_memfill_gmem_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/sda_action_memfill_gmem.sv
// Memfill kernel action: fetches four parameters over the SELF channels, then writes a
// counting pattern (seed, seed+1, ...) to memory with single-outstanding AXI4 INCR bursts
// that never cross a 4 KiB boundary, and finally raises done.
module sda_action_memfill_gmem #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_0r,
  output logic        go_0a,
  output logic        done_0r,
  input  logic        done_0a,
  output logic        paramaddr_0r0,
  output logic [31:0] paramaddr_0D,
  input  logic        paramaddr_0a,
  input  logic        paramdata_0r0,
  input  logic [31:0] paramdata_0D,
  output logic        paramdata_0a,
  sda_action_memfill_gmem_if.master gmem,
  output logic        status_err
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [8:0] MAX_LEN = 9'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_PADDR, S_PDATA, S_CALC, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                state;
  logic [1:0]            k;
  logic [31:0]           addr_lo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           remaining;
  logic [31:0]           beat_val;
  logic [8:0]            len;
  logic [8:0]            beat;
  logic [12:0]           to_boundary;
  logic [8:0]            cap;
  logic [8:0]            burst_len;
  logic                  unused_inputs;

  assign to_boundary = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE_LOG2;

  // Burst length is the smallest of remaining beats, MAX_BURST and beats left in this 4 KiB page.
  always_comb begin
    cap = MAX_LEN;
    if (to_boundary < 13'(MAX_BURST)) cap = to_boundary[8:0];
    burst_len = cap;
    if ({23'b0, cap} > remaining) burst_len = remaining[8:0];
  end

  // Main controller: parameter fetch, burst sequencing and completion handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= 2'd0;
      addr_lo    <= 32'd0;
      addr       <= '0;
      remaining  <= 32'd0;
      beat_val   <= 32'd0;
      len        <= 9'd0;
      beat       <= 9'd0;
      status_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_0r) begin
            status_err <= 1'b0;
            k          <= 2'd0;
            state      <= S_PADDR;
          end
        end
        S_PADDR: begin
          if (paramaddr_0a) state <= S_PDATA;
        end
        S_PDATA: begin
          if (paramdata_0r0) begin
            case (k)
              2'd0: addr_lo   <= paramdata_0D;
              2'd1: addr      <= ADDR_WIDTH'({paramdata_0D, addr_lo}) & ALIGN_MASK;
              2'd2: remaining <= paramdata_0D;
              default: beat_val <= paramdata_0D;
            endcase
            k     <= k + 2'd1;
            state <= (k == 2'd3) ? S_CALC : S_PADDR;
          end
        end
        S_CALC: begin
          if (remaining == 32'd0) begin
            state <= S_DONE;
          end else begin
            len   <= burst_len;
            state <= S_AW;
          end
        end
        S_AW: begin
          if (gmem.awready) begin
            beat  <= 9'd0;
            state <= S_W;
          end
        end
        S_W: begin
          if (gmem.wready) begin
            beat_val <= beat_val + 32'd1;
            beat     <= beat + 9'd1;
            if (beat == len - 9'd1) state <= S_B;
          end
        end
        S_B: begin
          if (gmem.bvalid) begin
            if (gmem.bresp != 2'b00) status_err <= 1'b1;
            addr      <= addr + (ADDR_WIDTH'(len) << SIZE_LOG2);
            remaining <= remaining - 32'(len);
            state     <= S_CALC;
          end
        end
        S_DONE: begin
          if (done_0a) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign go_0a         = (state == S_IDLE) && go_0r;
  assign done_0r       = (state == S_DONE);
  assign paramaddr_0r0 = (state == S_PADDR);
  assign paramaddr_0D  = paramaddr_0r0 ? {30'd0, k} : 32'd0;
  assign paramdata_0a  = (state == S_PDATA);

  assign gmem.awvalid  = (state == S_AW);
  assign gmem.awaddr   = addr;
  assign gmem.awlen    = 8'(len - 9'd1);
  assign gmem.awsize   = 3'(SIZE_LOG2);
  assign gmem.awburst  = 2'b01;
  assign gmem.awcache  = 4'b0011;
  assign gmem.awprot   = 3'b000;
  assign gmem.awqos    = 4'b0000;
  assign gmem.awregion = 4'b0000;
  assign gmem.awlock   = 1'b0;
  assign gmem.awuser   = '0;
  assign gmem.awid     = '0;

  assign gmem.wvalid   = (state == S_W);
  assign gmem.wdata    = DATA_WIDTH'(beat_val);
  assign gmem.wstrb    = '1;
  assign gmem.wlast    = (state == S_W) && (beat == len - 9'd1);
  assign gmem.wid      = '0;
  assign gmem.wuser    = '0;

  assign gmem.bready   = (state == S_B);

  assign gmem.arvalid  = 1'b0;
  assign gmem.araddr   = '0;
  assign gmem.arlen    = 8'd0;
  assign gmem.arsize   = 3'd0;
  assign gmem.arburst  = 2'b00;
  assign gmem.arlock   = 1'b0;
  assign gmem.arcache  = 4'd0;
  assign gmem.arprot   = 3'd0;
  assign gmem.arqos    = 4'd0;
  assign gmem.arregion = 4'd0;
  assign gmem.aruser   = '0;
  assign gmem.arid     = '0;
  assign gmem.rready   = 1'b0;

  assign unused_inputs = ^{gmem.bid, gmem.buser, gmem.arready, gmem.rid, gmem.rdata,
                           gmem.rresp, gmem.rlast, gmem.ruser, gmem.rvalid, 1'b0};

endmodule

// File: tb/tb_sda_action_memfill_gmem.sv
// Directed bench for sda_action_memfill_gmem: parameter responder, AXI write slave with
// optional random backpressure, burst/beat capture and hand-computed expected fills.
module tb_sda_action_memfill_gmem;

  localparam logic [22:0] EXP_ATTR = {3'd2, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
  localparam int MAXC = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go_0r = 1'b0;
  logic        go_0a;
  logic        done_0r;
  logic        done_0a = 1'b0;
  logic        paramaddr_0r0;
  logic [31:0] paramaddr_0D;
  logic        paramaddr_0a = 1'b0;
  logic        paramdata_0r0 = 1'b0;
  logic [31:0] paramdata_0D = 32'd0;
  logic        paramdata_0a;
  logic        status_err;

  sda_action_memfill_gmem_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) gmem ();

  sda_action_memfill_gmem #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1), .MAX_BURST(16)
  ) dut (
    .clk(clk), .reset(reset),
    .go_0r(go_0r), .go_0a(go_0a),
    .done_0r(done_0r), .done_0a(done_0a),
    .paramaddr_0r0(paramaddr_0r0), .paramaddr_0D(paramaddr_0D), .paramaddr_0a(paramaddr_0a),
    .paramdata_0r0(paramdata_0r0), .paramdata_0D(paramdata_0D), .paramdata_0a(paramdata_0a),
    .gmem(gmem),
    .status_err(status_err)
  );

  assign gmem.bid     = 1'b0;
  assign gmem.buser   = 1'b0;
  assign gmem.arready = 1'b0;
  assign gmem.rid     = 1'b0;
  assign gmem.rdata   = 32'd0;
  assign gmem.rresp   = 2'b00;
  assign gmem.rlast   = 1'b0;
  assign gmem.ruser   = 1'b0;
  assign gmem.rvalid  = 1'b0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          bp = 1'b0;
  int          err_idx = -1;
  int          resp_cnt = 0;
  bit          pend_data = 1'b0;
  logic [1:0]  pend_idx = 2'd0;
  bit          bpend = 1'b0;
  bit          ar_seen = 1'b0;
  logic [31:0] params [4];
  logic [63:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [22:0] aw_attr_q [$];
  logic [36:0] w_q [$];
  logic [31:0] pidx_q [$];
  bit          aw_hold = 1'b0;
  logic [72:0] aw_saved = '0;
  bit          w_hold = 1'b0;
  logic [37:0] w_saved = '0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {go_0a, done_0r, paramaddr_0r0, paramaddr_0D, paramdata_0a, gmem.awvalid,
                      gmem.wvalid, gmem.bready, gmem.wlast, status_err}, 128'd0);
  endtask

  // Responders drive on the falling edge, then record what will transfer on the next rising edge.
  always @(negedge clk) begin
    paramaddr_0a  = paramaddr_0r0 && (!bp || ($urandom_range(0, 1) == 1));
    paramdata_0r0 = pend_data;
    paramdata_0D  = pend_data ? params[pend_idx] : 32'd0;
    gmem.awready  = !bp || ($urandom_range(0, 2) == 0);
    gmem.wready   = !bp || ($urandom_range(0, 2) == 0);
    gmem.bvalid   = bpend && (!bp || ($urandom_range(0, 1) == 1));
    gmem.bresp    = (resp_cnt == err_idx) ? 2'b10 : 2'b00;
    #1;
    if (reset) begin
      pend_data = 1'b0;
      bpend     = 1'b0;
      aw_hold   = 1'b0;
      w_hold    = 1'b0;
    end else begin
      if (gmem.arvalid || gmem.rready) ar_seen = 1'b1;
      if (aw_hold) checkOutput("aw_stable", {gmem.awvalid, gmem.awaddr, gmem.awlen}, aw_saved);
      aw_hold  = gmem.awvalid && !gmem.awready;
      aw_saved = {1'b1, gmem.awaddr, gmem.awlen};
      if (w_hold) checkOutput("w_stable", {gmem.wvalid, gmem.wlast, gmem.wstrb, gmem.wdata}, w_saved);
      w_hold  = gmem.wvalid && !gmem.wready;
      w_saved = {1'b1, gmem.wlast, gmem.wstrb, gmem.wdata};
      if (gmem.awvalid && gmem.awready) begin
        aw_addr_q.push_back(gmem.awaddr);
        aw_len_q.push_back(gmem.awlen);
        aw_attr_q.push_back({gmem.awsize, gmem.awburst, gmem.awcache, gmem.awprot, gmem.awlock,
                             gmem.awqos, gmem.awregion, gmem.awid, gmem.awuser});
      end
      if (gmem.bvalid && gmem.bready) begin
        bpend = 1'b0;
        resp_cnt++;
      end
      if (gmem.wvalid && gmem.wready) begin
        w_q.push_back({gmem.wlast, gmem.wstrb, gmem.wdata});
        if (gmem.wlast) bpend = 1'b1;
      end
      if (paramdata_0r0 && paramdata_0a) pend_data = 1'b0;
      if (paramaddr_0r0 && paramaddr_0a) begin
        pidx_q.push_back(paramaddr_0D);
        pend_idx  = paramaddr_0D[1:0];
        pend_data = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] dst, input logic [31:0] n, input logic [31:0] s,
                               input bit stall, input int err_burst, input bit exp_err,
                               input int abort_beat, output int done_cyc, output int aw_cyc);
    params[0] = dst[31:0];
    params[1] = dst[63:32];
    params[2] = n;
    params[3] = s;
    bp = stall;
    err_idx = err_burst;
    resp_cnt = 0;
    ar_seen = 1'b0;
    aw_addr_q.delete(); aw_len_q.delete(); aw_attr_q.delete(); w_q.delete(); pidx_q.delete();
    done_cyc = -1;
    aw_cyc = -1;
    @(negedge clk);
    go_0r = 1'b1;
    #2;
    checkOutput("go_0a", go_0a, 1);
    @(negedge clk);
    go_0r = 1'b0;
    checkOutput("status_err_on_go", status_err, 0);
    for (int c = 1; c <= MAXC; c++) begin
      if (c > 1) @(negedge clk);
      if (gmem.awvalid && aw_cyc < 0) aw_cyc = c;
      if (abort_beat >= 0 && gmem.wvalid && w_q.size() == abort_beat) begin
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("abort_reset_outputs");
        reset = 1'b0;
        break;
      end
      if (done_0r) begin
        done_cyc = c;
        checkOutput("status_err_at_done", status_err, exp_err);
        done_0a = 1'b1;
        @(negedge clk);
        done_0a = 1'b0;
        checkOutput("done_dropped", done_0r, 0);
        break;
      end
    end
    if (abort_beat < 0) checkOutput("done_reached", done_cyc > 0, 1);
  endtask

  task automatic checkRun(input int nb, input logic [63:0] ea0, input logic [63:0] ea1,
                          input logic [63:0] ea2, input int el0, input int el1, input int el2,
                          input logic [31:0] s, input int n);
    logic [63:0] ea [3];
    int el [3];
    int beat;
    logic [31:0] d;
    ea = '{ea0, ea1, ea2};
    el = '{el0, el1, el2};
    checkOutput("param_count", pidx_q.size(), 4);
    for (int i = 0; i < 4 && i < pidx_q.size(); i++)
      checkOutput($sformatf("param_idx[%0d]", i), pidx_q[i], i);
    checkOutput("burst_count", aw_addr_q.size(), nb);
    for (int i = 0; i < nb && i < aw_addr_q.size(); i++) begin
      checkOutput($sformatf("awaddr[%0d]", i), aw_addr_q[i], ea[i]);
      checkOutput($sformatf("awlen[%0d]", i), aw_len_q[i], el[i] - 1);
      checkOutput($sformatf("aw_attr[%0d]", i), aw_attr_q[i], EXP_ATTR);
    end
    checkOutput("beat_count", w_q.size(), n);
    beat = 0;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < el[i]; j++) begin
        d = s + 32'(beat);
        if (beat < w_q.size())
          checkOutput($sformatf("beat[%0d]", beat), w_q[beat], {(j == el[i] - 1), 4'hF, d});
        beat++;
      end
    end
    checkOutput("ar_idle", ar_seen, 0);
  endtask

  int dc, ac;

  // Directed scenarios, each with hand-computed burst lists and latencies.
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_outputs");
    reset = 1'b0;

    $display("[TB] basic fill 0x1000 N=20");
    applyStimulus(64'h1000, 32'd20, 32'h100, 1'b0, -1, 1'b0, -1, dc, ac);
    checkRun(2, 64'h1000, 64'h1040, 64'h0, 16, 4, 0, 32'h100, 20);
    checkOutput("aw_latency", ac, 10);
    checkOutput("done_latency", dc, 36);

    $display("[TB] 4 KiB split 0x0FF8 N=8");
    applyStimulus(64'h0FF8, 32'd8, 32'h0, 1'b0, -1, 1'b0, -1, dc, ac);
    checkRun(2, 64'h0FF8, 64'h1000, 64'h0, 2, 6, 0, 32'h0, 8);
    checkOutput("split_done_latency", dc, 24);

    $display("[TB] zero length");
    applyStimulus(64'h3000, 32'd0, 32'h7, 1'b0, -1, 1'b0, -1, dc, ac);
    checkRun(0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 32'h7, 0);
    checkOutput("n0_no_aw", ac, -1);
    checkOutput("n0_done_latency", dc, 10);

    $display("[TB] backpressure, unaligned 64-bit address");
    applyStimulus(64'h1_0000_0FC3, 32'd40, 32'hABCD_0000, 1'b1, -1, 1'b0, -1, dc, ac);
    checkRun(3, 64'h1_0000_0FC0, 64'h1_0000_1000, 64'h1_0000_1040, 16, 16, 8, 32'hABCD_0000, 40);

    $display("[TB] SLVERR on second burst");
    applyStimulus(64'h1000, 32'd40, 32'h5, 1'b0, 1, 1'b1, -1, dc, ac);
    checkRun(3, 64'h1000, 64'h1040, 64'h1080, 16, 16, 8, 32'h5, 40);

    $display("[TB] reset during beat 3");
    applyStimulus(64'h1000, 32'd20, 32'h100, 1'b0, -1, 1'b0, 3, dc, ac);
    checkOutput("abort_beats", w_q.size(), 3);

    $display("[TB] clean fill after reset");
    applyStimulus(64'h1000, 32'd20, 32'h100, 1'b0, -1, 1'b0, -1, dc, ac);
    checkRun(2, 64'h1000, 64'h1040, 64'h0, 16, 4, 0, 32'h100, 20);
    checkOutput("rerun_done_latency", dc, 36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
